// File: rtl/cra_diag_pkg.sv
// Shared definitions for the CRA diagnostic initiator and responder: op codes,
// readback select codes and the initiator FSM states.
package cra_diag_pkg;

   typedef enum logic [1:0] {
      LOAD_DIAG = 2'd0,
      READ_ADR  = 2'd1,
      READ_LOC  = 2'd2,
      READ_SBR  = 2'd3
   } op_e;

   localparam logic [2:0] SEL_STACK  = 3'd0;
   localparam logic [2:0] SEL_SBR_LO = 3'd2;
   localparam logic [2:0] SEL_SBR_HI = 3'd3;
   localparam logic [2:0] SEL_ADR_LO = 3'd4;
   localparam logic [2:0] SEL_ADR_HI = 3'd5;
   localparam logic [2:0] SEL_LOC_LO = 3'd6;
   localparam logic [2:0] SEL_LOC_HI = 3'd7;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_HI     = 3'd1,
      WR_LO     = 3'd2,
      RD_SEL_LO = 3'd3,
      RD_SEL_HI = 3'd4,
      RD_STACK  = 3'd5,
      RESP      = 3'd6
   } state_e;

   function automatic logic [2:0] sel_lo(input op_e op);
      case (op)
         READ_ADR: sel_lo = SEL_ADR_LO;
         READ_LOC: sel_lo = SEL_LOC_LO;
         READ_SBR: sel_lo = SEL_SBR_LO;
         default:  sel_lo = SEL_STACK;
      endcase
   endfunction

   function automatic logic [2:0] sel_hi(input op_e op);
      case (op)
         READ_ADR: sel_hi = SEL_ADR_HI;
         READ_LOC: sel_hi = SEL_LOC_HI;
         READ_SBR: sel_hi = SEL_SBR_HI;
         default:  sel_hi = SEL_STACK;
      endcase
   endfunction

endpackage

// File: rtl/cra_diag_master.sv
// EBUS diagnostic initiator for the CRA diag port: loads the dispatch address and
// reads back ADR/LOC/SBR state. Define CRA_DIAG_STACK_READ_EN to add the stack read.
module cra_diag_master
   import cra_diag_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int HOLD   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [1:0]  cmdOp,
   input  logic [0:10] cmdAdr,
   output logic        rspValid,
   input  logic        rspReady,
   output logic [0:10] rspData,
   output logic        rspFlag,
   output logic        rspErr,
   output logic [4:6]  diag,
   output logic        diaFunc051,
   output logic        diaFunc052,
   output logic        diagReadFunc14X,
   output logic [0:35] ebusOut,
   output logic        drivingEBUS,
`ifdef CRA_DIAG_STACK_READ_EN
   output logic [0:4]  stackAdr,
`endif
   input  logic [0:35] ebusIn
);

`ifdef CRA_DIAG_STACK_READ_EN
   localparam bit STACK_EN = 1'b1;
`else
   localparam bit STACK_EN = 1'b0;
`endif

   localparam logic [3:0] HOLD_LD   = 4'(HOLD - 1);
   localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

   state_e      state, state_nxt;
   logic [3:0]  cnt, cnt_ld;
   logic        last;
   logic        accept;
   op_e         op_q;
   logic [0:10] adr_q;
   logic        unused_ebus;

   assign last        = (cnt == 4'd0);
   assign accept      = cmdValid && cmdReady;
   assign unused_ebus = ^ebusIn[6:35];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         // one counter serves every timed state; it reloads whenever the state changes
         if (state_nxt != state)
            cnt <= cnt_ld;
         else if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

   always_comb begin
      state_nxt       = state;
      cmdReady        = 1'b0;
      rspValid        = 1'b0;
      diaFunc051      = 1'b0;
      diaFunc052      = 1'b0;
      diagReadFunc14X = 1'b0;
      drivingEBUS     = 1'b0;
      diag            = 3'd0;
      ebusOut         = '0;
      case (state)
         IDLE: begin
            cmdReady = 1'b1;
            if (cmdValid) begin
               case (op_e'(cmdOp))
                  LOAD_DIAG: state_nxt = WR_HI;
                  READ_SBR:  state_nxt = STACK_EN ? RD_SEL_LO : RESP;
                  default:   state_nxt = RD_SEL_LO;
               endcase
            end
         end
         WR_HI: begin
            diaFunc052     = 1'b1;
            drivingEBUS    = 1'b1;
            ebusOut[1:5]   = adr_q[0:4];
            if (last) state_nxt = WR_LO;
         end
         WR_LO: begin
            diaFunc051     = 1'b1;
            drivingEBUS    = 1'b1;
            ebusOut[0:5]   = adr_q[5:10];
            if (last) state_nxt = RESP;
         end
         RD_SEL_LO: begin
            diagReadFunc14X = 1'b1;
            diag            = sel_lo(op_q);
            if (last) state_nxt = RD_SEL_HI;
         end
         RD_SEL_HI: begin
            diagReadFunc14X = 1'b1;
            diag            = sel_hi(op_q);
            if (last) state_nxt = (STACK_EN && op_q == READ_SBR) ? RD_STACK : RESP;
         end
         RD_STACK: begin
            diagReadFunc14X = 1'b1;
            diag            = SEL_STACK;
            if (last) state_nxt = RESP;
         end
         RESP: begin
            rspValid = 1'b1;
            if (rspReady) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      case (state_nxt)
         WR_HI, WR_LO:                  cnt_ld = HOLD_LD;
         RD_SEL_LO, RD_SEL_HI, RD_STACK: cnt_ld = SETTLE_LD;
         default:                       cnt_ld = 4'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q    <= LOAD_DIAG;
         adr_q   <= '0;
         rspData <= '0;
         rspFlag <= 1'b0;
         rspErr  <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= op_e'(cmdOp);
            adr_q   <= cmdAdr;
            rspData <= '0;
            rspFlag <= 1'b0;
            rspErr  <= (op_e'(cmdOp) == READ_SBR) && !STACK_EN;
         end
         // each read half is sampled at the end of its last settle cycle
         if (state == RD_SEL_LO && last)
            rspData[5:10] <= ebusIn[0:5];
         if (state == RD_SEL_HI && last) begin
            rspData[0:4] <= ebusIn[1:5];
            rspFlag      <= (op_q == READ_LOC) ? 1'b0 : ebusIn[0];
         end
      end
   end

`ifdef CRA_DIAG_STACK_READ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stackAdr <= '0;
      else if (state == RD_STACK && last)
         stackAdr <= ebusIn[1:5];
   end
`endif

endmodule
